// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// access-size / legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  function automatic logic [1:0] access_size(input logic [2:0] funct);
    case (funct)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct, input logic [1:0] off);
    case (access_size(funct))
      SZ_H:    return off[0];
      SZ_W:    return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Stores only know B/H/W; loads additionally reject 011, 110, 111.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct);
    if (we) begin
      return (funct > F3_W);
    end else begin
      return (funct == 3'b011) || (funct == 3'b110) || (funct == 3'b111);
    end
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a RAM word and
// builds the read-modify-write word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata_lo,
  output logic [31:0] load_word,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load lane select and sign/zero extension
  always_comb begin
    byte_s = rdata[{off, 3'b000} +: 8];
    half_s = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct)
      F3_B:    load_word = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_word = {24'd0, byte_s};
      F3_H:    load_word = {{16{half_s[15]}}, half_s};
      F3_HU:   load_word = {16'd0, half_s};
      F3_W:    load_word = rdata;
      default: load_word = 32'd0;
    endcase
  end

  // Store merge: replace the addressed lane, keep the rest of the word
  always_comb begin
    merged_word = rdata;
    case (access_size(funct))
      SZ_B:    merged_word[{off, 3'b000} +: 8] = wdata_lo[7:0];
      SZ_H:    merged_word[{off[1], 4'b0000} +: 16] = wdata_lo;
      default: merged_word = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator for a synchronous-read,
// word-wide RAM with sub-word read-modify-write and misalignment checking.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct_q, funct_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [31:0]       load_word_s;
  logic [31:0]       merged_word_s;
  logic              unused_addr_s;

  // Upper address bits are deliberately dropped: the RAM wraps.
  assign unused_addr_s = ^req_addr[31:ADDR_W+2];

  lsu_lane_align u_align (
    .funct       (funct_q),
    .off         (addr_q[1:0]),
    .rdata       (mem_rdata),
    .wdata_lo    (wdata_q[15:0]),
    .load_word   (load_word_s),
    .merged_word (merged_word_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct_d      = funct_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    load_data_d  = load_data_q;
    mem_addr_d   = mem_addr_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          we_d        = req_we;
          funct_d     = req_funct;
          addr_d      = req_addr[ADDR_W+1:0];
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (is_illegal(req_we, req_funct) || is_misaligned(req_funct, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            load_data_d  = 32'd0;
          end else begin
            // Outputs are registered, so the ISSUE-cycle strobe is set up here.
            state_d    = ST_ISSUE;
            mem_addr_d = req_addr[ADDR_W+1:2];
            if (req_we && (req_funct == F3_W)) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              mem_re_d = 1'b1;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_q && (funct_q == F3_W)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          load_data_d  = 32'd0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (we_q) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged_word_s;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          load_data_d  = load_word_s;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        load_data_d  = 32'd0;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        load_data_d = 32'd0;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        load_data_d = 32'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct_q      <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_data_q  <= 32'd0;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct_q      <= funct_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      load_data_q  <= load_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign load_data  = load_data_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  // Strobes are killed in the reset cycle itself, not one edge later.
  assign mem_re     = mem_re_q & ~reset;
  assign mem_we     = mem_we_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word RAM behind the DUT and a
// byte-arithmetic reference model of memory contents and response timing.
module tb_load_store_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] ram      [0:1023];
  logic [31:0] ref_word [0:1023];

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct  (req_funct),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .load_data  (load_data),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read block RAM
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request end to end: model prediction, drive, observe, model update.
  task automatic txn(input logic we, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] ld_obs,
                     output logic [31:0] wr_obs);
    logic        legal, err, got;
    int          n, idx, sh, lat, lat_obs, re_cnt, we_cnt, k;
    logic [31:0] mask, cur, expl, expw;

    legal = we ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n     = 1 << f[1:0];
    err   = !legal || ((a % n) != 0);
    idx   = (a >> 2) % 1024;
    sh    = 8 * (a % 4);
    mask  = (n == 1) ? 32'h0000_00FF : (n == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    cur   = ref_word[idx];
    expl  = (cur >> sh) & mask;
    if (legal && !f[2] && n < 4 && expl[8*n-1]) expl = expl | ~mask;
    expw  = (cur & ~(mask << sh)) | ((wd & mask) << sh);
    if (err) begin
      expl = 32'd0; lat = 1;
    end else if (we) begin
      expl = 32'd0; lat = (n == 4) ? 2 : 4;
    end else begin
      lat = 3;
    end

    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_funct = f; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;

    re_cnt = 0; we_cnt = 0; got = 1'b0; lat_obs = 0;
    ld_obs = 32'hxxxx_xxxx; wr_obs = 32'hxxxx_xxxx;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      chk("re_we_exclusive", mem_re & mem_we, 1'b0);
      if (mem_re) begin
        re_cnt++;
        chk("re_addr", mem_addr, idx);
      end
      if (mem_we) begin
        we_cnt++;
        wr_obs = mem_wdata;
        chk("we_addr", mem_addr, idx);
        chk("we_data", mem_wdata, err ? 32'd0 : (n == 4 ? wd : expw));
      end
      if (resp_valid) begin
        got     = 1'b1;
        lat_obs = c;
        ld_obs  = load_data;
        chk("resp_err", resp_err, err);
        chk("load_data", load_data, expl);
        chk("ready_in_resp", req_ready, 1'b0);
      end
    end
    chk("resp_seen", got, 1'b1);
    chk("latency", lat_obs, lat);
    chk("re_count", re_cnt, (err || (we && n == 4)) ? 0 : 1);
    chk("we_count", we_cnt, (err || !we) ? 0 : 1);
    @(negedge clk);
    chk("resp_one_cycle", resp_valid, 1'b0);
    chk("ready_after_resp", req_ready, 1'b1);
    if (!err && we) ref_word[idx] = (n == 4) ? wd : expw;
  endtask

  initial begin
    logic [31:0] ld, wr, a;
    int          re_cnt, resp_cnt;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Initialise the working region (words 0x40..0x47) through the DUT.
    txn(1'b1, 3'b010, 32'h100, 32'h8899_AABB, ld, wr);
    for (int i = 1; i < 8; i++) txn(1'b1, 3'b010, 32'h100 + 4 * i, $urandom, ld, wr);

    txn(1'b0, 3'b000, 32'h100, 32'd0, ld, wr); chk("tp_lb", ld, 32'hFFFF_FFBB);
    txn(1'b0, 3'b100, 32'h103, 32'd0, ld, wr); chk("tp_lbu", ld, 32'h0000_0088);
    txn(1'b0, 3'b001, 32'h102, 32'd0, ld, wr); chk("tp_lh", ld, 32'hFFFF_8899);
    txn(1'b0, 3'b101, 32'h102, 32'd0, ld, wr); chk("tp_lhu", ld, 32'h0000_8899);
    txn(1'b0, 3'b010, 32'h100, 32'd0, ld, wr); chk("tp_lw", ld, 32'h8899_AABB);

    txn(1'b1, 3'b010, 32'h100, 32'h1122_3344, ld, wr);
    txn(1'b1, 3'b000, 32'h101, 32'hDEAD_BEEF, ld, wr); chk("tp_sb_merge", wr, 32'h1122_EF44);
    txn(1'b1, 3'b010, 32'h100, 32'h1122_3344, ld, wr);
    txn(1'b1, 3'b001, 32'h102, 32'h0000_CAFE, ld, wr); chk("tp_sh_merge", wr, 32'hCAFE_3344);

    txn(1'b1, 3'b010, 32'h104, 32'hA5A5_A5A5, ld, wr); chk("tp_sw_data", wr, 32'hA5A5_A5A5);
    txn(1'b0, 3'b010, 32'h104, 32'd0, ld, wr); chk("tp_sw_readback", ld, 32'hA5A5_A5A5);

    txn(1'b0, 3'b001, 32'h101, 32'd0, ld, wr); chk("tp_mis_ld", ld, 32'd0);
    txn(1'b0, 3'b011, 32'h100, 32'd0, ld, wr); chk("tp_ill_ld", ld, 32'd0);
    txn(1'b1, 3'b011, 32'h100, 32'h1234_5678, ld, wr);
    txn(1'b1, 3'b010, 32'h102, 32'h1234_5678, ld, wr);

    // Reset during WRITE of an SB: write suppressed, no response.
    txn(1'b1, 3'b010, 32'h100, 32'h1122_3344, ld, wr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct = 3'b000;
    req_addr = 32'h101; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    resp_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    chk("write_cycle_we", mem_we, 1'b1);
    reset = 1'b1;
    #1 chk("rst_gates_we", mem_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    if (resp_valid) resp_cnt++;
    chk("aborted_no_resp", resp_cnt, 0);
    chk("ready_after_rst", req_ready, 1'b1);
    chk("ram_unchanged", ram[32'h40], 32'h1122_3344);
    txn(1'b0, 3'b010, 32'h100, 32'd0, ld, wr); chk("abort_readback", ld, 32'h1122_3344);

    // LW held on req_valid through its own response is accepted once.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct = 3'b010; req_addr = 32'h104;
    re_cnt = 0; resp_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_re) re_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        chk("held_load_data", load_data, 32'hA5A5_A5A5);
        chk("held_ready_in_resp", req_ready, 1'b0);
        req_valid = 1'b0;
      end
    end
    chk("held_re_once", re_cnt, 1);
    chk("held_resp_once", resp_cnt, 1);

    // Randomised traffic over the working region with random upper bits.
    for (int i = 0; i < 60; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'h100 + $urandom_range(0, 31));
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, ld, wr);
    end
    for (int i = 0; i < 8; i++) chk("final_ram", ram[32'h40 + i], ref_word[32'h40 + i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
